hwpe_stream_split_stride_buf: RTL and testbench

- Splits one wide HWPE-Stream input into NB_OUT_STREAMS narrower output streams.
- Each input beat is cut into ELEMENT_WIDTH elements and distributed in one of two runtime-selectable orders: strided (element-interleaved) or contiguous.
- Every output has its own FIFO, so slow consumers do not stall fast ones until a FIFO fills.
- Sits between wide engine datapaths and multiple TCDM store/streamer channels.

---
 rtl/hwpe_stream_split_stride_buf_if.sv | 16 +
 rtl/hwpe_stream_split_stride_buf.sv | 103 ++++++++++
 tb/tb_hwpe_stream_split_stride_buf.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_split_stride_buf_if.sv
// HWPE-Stream handshake bundle: data, byte strobes, valid/ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  valid;
    logic                  ready;

    modport source (output data, strb, valid, input ready);
    modport sink   (input data, strb, valid, output ready);
    modport master (output data, strb, valid, input ready);
    modport slave  (input data, strb, valid, output ready);
endinterface

// File: rtl/hwpe_stream_split_stride_buf.sv
// Splits one wide HWPE stream into NB_OUT_STREAMS narrow streams, element-strided
// or contiguous, with an independent registered FIFO behind every output.
module hwpe_stream_split_stride_buf #(
    parameter int unsigned NB_OUT_STREAMS = 4,
    parameter int unsigned DATA_WIDTH_IN  = 256,
    parameter int unsigned ELEMENT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   mode_i,
    hwpe_stream_intf_stream.sink   push_i,
    hwpe_stream_intf_stream.source pop_o [NB_OUT_STREAMS],
    output logic                   busy_o
);
    localparam int unsigned DW_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS;
    localparam int unsigned EPO    = DW_OUT / ELEMENT_WIDTH;
    localparam int unsigned EB     = ELEMENT_WIDTH / 8;
    localparam int unsigned SW_OUT = DW_OUT / 8;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [NB_OUT_STREAMS-1:0] full;
    logic [NB_OUT_STREAMS-1:0] nz_d;
    logic                      push_accept;
    logic                      busy_q;

    // Ready is a pure function of FIFO fill, so every FIFO can take the beat together.
    assign push_i.ready = ~(|full);
    assign push_accept  = push_i.valid & push_i.ready;
    assign busy_o       = busy_q;

    for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : g_fifo
        logic [DW_OUT-1:0] wdata;
        logic [SW_OUT-1:0] wstrb;
        logic [DW_OUT-1:0] mem_data [FIFO_DEPTH];
        logic [SW_OUT-1:0] mem_strb [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              pop;

        // Element routing: strided takes e = s*N + i, contiguous takes e = i*EPO + s.
        for (genvar s = 0; s < EPO; s++) begin : g_slot
            localparam int unsigned ES = s * NB_OUT_STREAMS + i;
            localparam int unsigned EC = i * EPO + s;
            assign wdata[s*ELEMENT_WIDTH +: ELEMENT_WIDTH] = mode_i ?
                push_i.data[ES*ELEMENT_WIDTH +: ELEMENT_WIDTH] :
                push_i.data[EC*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            assign wstrb[s*EB +: EB] = mode_i ? push_i.strb[ES*EB +: EB] : push_i.strb[EC*EB +: EB];
        end

        assign pop     = (cnt_q != '0) & pop_o[i].ready;
        assign full[i] = (cnt_q == CNT_W'(FIFO_DEPTH));

        always_comb begin
            cnt_d = cnt_q;
            if (push_accept && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!push_accept && pop) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        assign nz_d[i] = !clear_i && (cnt_d != '0);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else if (clear_i) begin
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push_accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)         rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end

        // Storage needs no reset; the count alone decides what is valid.
        always_ff @(posedge clk_i) begin
            if (push_accept && !clear_i) begin
                mem_data[wr_ptr_q] <= wdata;
                mem_strb[wr_ptr_q] <= wstrb;
            end
        end

        assign pop_o[i].valid = (cnt_q != '0);
        assign pop_o[i].data  = mem_data[rd_ptr_q];
        assign pop_o[i].strb  = mem_strb[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |nz_d;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_split_stride_buf.sv
// Scoreboard bench: stimulus pushes model-derived expectations, a negedge monitor checks every pop.
module tb_hwpe_stream_split_stride_buf;
    localparam int NB  = 4;
    localparam int EW  = 16;
    localparam int EPO = 4;
    localparam int DWI = 256;
    localparam int DWO = 64;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic mode_i = 1'b0;
    logic busy_o;
    logic [NB-1:0] rdy = '1;
    logic rand_rdy = 1'b0;

    logic [DWO-1:0] pd [NB];
    logic [7:0]     ps [NB];
    logic           pv [NB];

    int total = 0;
    int bad   = 0;
    logic [71:0] exp_q [NB][$];

    hwpe_stream_intf_stream #(.DATA_WIDTH(DWI)) push_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DWO)) pop_if [NB] ();

    hwpe_stream_split_stride_buf #(
        .NB_OUT_STREAMS(NB), .DATA_WIDTH_IN(DWI), .ELEMENT_WIDTH(EW), .FIFO_DEPTH(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .mode_i(mode_i),
        .push_i(push_if), .pop_o(pop_if), .busy_o(busy_o)
    );

    for (genvar g = 0; g < NB; g++) begin : g_pop
        assign pd[g] = pop_if[g].data;
        assign ps[g] = pop_if[g].strb;
        assign pv[g] = pop_if[g].valid;
        assign pop_if[g].ready = rdy[g];
    end

    always #5 clk_i = ~clk_i;

    // Reference: place each input element by the stated index rules.
    function automatic logic [71:0] ref_out(input logic [DWI-1:0] d, input logic [31:0] s,
                                            input logic m, input int o);
        logic [DWO-1:0] od = '0;
        logic [7:0]     os = '0;
        int oo, ss;
        for (int e = 0; e < NB * EPO; e++) begin
            if (m) begin oo = e % NB; ss = e / NB; end
            else   begin oo = e / EPO; ss = e % EPO; end
            if (oo == o) begin
                od[ss*EW +: EW] = d[e*EW +: EW];
                os[ss*2 +: 2]   = s[e*2 +: 2];
            end
        end
        return {os, od};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Monitor: pops are checked before this cycle's push is recorded.
    always @(negedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int i = 0; i < NB; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (pv[i] && rdy[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_pop%0d", i), {ps[i], pd[i]}, 72'hx);
                    end else begin
                        check($sformatf("pop%0d", i), {ps[i], pd[i]}, exp_q[i].pop_front());
                    end
                end
            end
            if (push_if.valid && push_if.ready) begin
                for (int i = 0; i < NB; i++)
                    exp_q[i].push_back(ref_out(push_if.data, push_if.strb, mode_i, i));
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (rand_rdy) rdy = 4'($urandom);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [DWI-1:0] d, input logic [31:0] s, input logic m);
        int n = 0;
        push_if.data  = d;
        push_if.strb  = s;
        mode_i        = m;
        push_if.valid = 1'b1;
        forever begin
            @(negedge clk_i);
            if (push_if.ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
        push_if.valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        rand_rdy = 1'b0;
        rdy = '1;
        while ((busy_o || exp_q[0].size() != 0) && n < 200) begin
            cyc(1);
            n++;
        end
        cyc(1);
        check({name, "_busy"}, busy_o, 0);
        for (int i = 0; i < NB; i++)
            check($sformatf("%s_left%0d", name, i), exp_q[i].size(), 0);
    endtask

    logic [DWI-1:0] ramp;
    logic [DWI-1:0] b1, b2, b3;
    logic [71:0]    x;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int e = 0; e < 16; e++) ramp[e*EW +: EW] = 16'(e);
        push_if.valid = 1'b0;
        push_if.data  = '0;
        push_if.strb  = '0;
        #12;
        for (int i = 0; i < NB; i++) check($sformatf("rst_valid%0d", i), pv[i], 0);
        check("rst_busy", busy_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        cyc(1);
        check("rst_ready", push_if.ready, 1);

        // Strided ramp beat, one-cycle latency, valid for one cycle.
        send(ramp, '1, 1'b1);
        check("strided_valid", pv[0], 1);
        check("strided_out0", pd[0], 64'h000C_0008_0004_0000);
        check("strided_out3", pd[3], 64'h000F_000B_0007_0003);
        cyc(1);
        check("strided_one_cycle", pv[0], 0);

        send(ramp, '1, 1'b0);
        check("contig_out0", pd[0], 64'h0003_0002_0001_0000);
        check("contig_out2", pd[2], 64'h000B_000A_0009_0008);
        cyc(1);

        send(ramp, 32'h0000_0003, 1'b1);
        check("strb_s0", ps[0], 8'h03);
        check("strb_s1", ps[1], 8'h00);
        check("strb_s3", ps[3], 8'h00);
        cyc(1);
        send(ramp, 32'h0000_000C, 1'b0);
        check("strb_c0", ps[0], 8'h0C);
        check("strb_c1", ps[1], 8'h00);
        drain("directed");

        // Backpressure on output 2.
        b1 = {8{32'h1111_0001}};
        b2 = {8{32'h2222_0002}};
        b3 = {8{32'h3333_0003}};
        rdy = 4'b1011;
        send(b1, '1, 1'b1);
        send(b2, '1, 1'b0);
        check("bp_ready_low", push_if.ready, 0);
        push_if.data  = b3;
        push_if.strb  = '1;
        mode_i        = 1'b1;
        push_if.valid = 1'b1;
        cyc(3);
        x = ref_out(b1, '1, 1'b1, 2);
        check("bp_ready_held", push_if.ready, 0);
        check("bp_out2_valid", pv[2], 1);
        check("bp_out2_hold", pd[2], x[63:0]);
        check("bp_out0_drained", pv[0], 0);
        rdy[2] = 1'b1;
        cyc(1);
        check("bp_ready_back", push_if.ready, 1);
        cyc(1);
        push_if.valid = 1'b0;
        drain("bp");

        // Random streaming with random readies and toggling mode.
        rand_rdy = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                mode_i = 1'($urandom);
                cyc(1);
            end
            send({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 $urandom, 1'(k));
        end
        drain("rand");

        // Synchronous clear with two beats buffered.
        rdy = '0;
        send(b1, '1, 1'b1);
        send(b2, '1, 1'b1);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        for (int i = 0; i < NB; i++) check($sformatf("clr_valid%0d", i), pv[i], 0);
        check("clr_busy", busy_o, 0);
        check("clr_ready", push_if.ready, 1);
        rdy = '1;
        send(ramp, '1, 1'b1);
        check("clr_next_out1", pd[1], 64'h000D_0009_0005_0001);
        drain("clr");

        // Asynchronous reset mid-stream.
        rdy = '0;
        send(b2, '1, 1'b0);
        send(b3, '1, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        for (int i = 0; i < NB; i++) check($sformatf("arst_valid%0d", i), pv[i], 0);
        check("arst_busy", busy_o, 0);
        cyc(1);
        rst_ni = 1'b1;
        check("arst_ready", push_if.ready, 1);
        rdy = '1;
        send(ramp, '1, 1'b0);
        check("arst_next_out1", pd[1], 64'h0007_0006_0005_0004);
        drain("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
